// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared CPU pipeline definitions: hazard FSM state encodings, the NOP word
// used to squash IF/ID, and the stall performance-counter width.
package pipeline_hazard_ctrl_pkg;

    localparam int          CNT_W     = 16;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_RUN        = 2'd0,
        ST_LOAD_USE   = 2'd1,
        ST_MD_WAIT    = 2'd2,
        ST_FETCH_WAIT = 2'd3
    } hz_state_e;

    typedef struct packed {
        logic pc_stall;
        logic stall;
        logic if_flush;
        logic id_flush;
    } hz_ctrl_t;

endpackage

// File: rtl/pipeline_hazard_ctrl_hazard_detect.sv
// Combinational load-use comparator between the load in execute and the
// sources read by the instruction in decode. x0 never creates a hazard.
module hazard_detect
    import pipeline_hazard_ctrl_pkg::*;
(
    input  logic [4:0] ID_rs1,
    input  logic [4:0] ID_rs2,
    input  logic       ID_use_rs1,
    input  logic       ID_use_rs2,
    input  logic [4:0] EX_rd,
    input  logic       EX_mem_read,
    output logic       load_use_o
);

    logic rs1_hit;
    logic rs2_hit;

    assign rs1_hit    = ID_use_rs1 && (ID_rs1 == EX_rd);
    assign rs2_hit    = ID_use_rs2 && (ID_rs2 == EX_rd);
    assign load_use_o = EX_mem_read && (EX_rd != 5'd0) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: Mealy FSM for load-use, multicycle mul/div and
// fetch-wait stalls plus branch flushes, with a saturating stall counter.
//
// state      | meaning
// RUN        | normal flow; hazards detected and acted on this cycle
// LOAD_USE   | second half of the 1-cycle load-use bubble, outputs idle
// MD_WAIT    | mul/div busy, front end frozen until md_done
// FETCH_WAIT | imem not ready, PC held and IF/ID squashed to NOP
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       ID_rs1,
    input  logic [4:0]       ID_rs2,
    input  logic             ID_use_rs1,
    input  logic             ID_use_rs2,
    input  logic [4:0]       EX_rd,
    input  logic             EX_mem_read,
    input  logic             EX_br_taken,
    input  logic             EX_md_start,
    input  logic             md_done,
    input  logic             imem_ready,
    output logic             pc_stall,
    output logic             stall,
    output logic             IF_flush,
    output logic             ID_flush,
    output logic [1:0]       hz_state,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam hz_ctrl_t CTRL_IDLE   = '{pc_stall: 1'b0, stall: 1'b0, if_flush: 1'b0, id_flush: 1'b0};
    localparam hz_ctrl_t CTRL_STALL  = '{pc_stall: 1'b1, stall: 1'b1, if_flush: 1'b0, id_flush: 1'b1};
    localparam hz_ctrl_t CTRL_REDIR  = '{pc_stall: 1'b0, stall: 1'b0, if_flush: 1'b1, id_flush: 1'b1};
    localparam hz_ctrl_t CTRL_FBUBBL = '{pc_stall: 1'b1, stall: 1'b0, if_flush: 1'b1, id_flush: 1'b0};

    hz_state_e        state_q, state_d;
    hz_ctrl_t         ctrl_d, ctrl;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic             load_use;

    hazard_detect u_hazard_detect (
        .ID_rs1      (ID_rs1),
        .ID_rs2      (ID_rs2),
        .ID_use_rs1  (ID_use_rs1),
        .ID_use_rs2  (ID_use_rs2),
        .EX_rd       (EX_rd),
        .EX_mem_read (EX_mem_read),
        .load_use_o  (load_use)
    );

    always_comb begin
        state_d = state_q;
        ctrl_d  = CTRL_IDLE;
        case (state_q)
            ST_RUN: begin
                if (EX_br_taken) begin
                    ctrl_d = CTRL_REDIR;
                end else if (EX_md_start) begin
                    // A unit that finishes in its start cycle needs no wait at all.
                    if (!md_done) begin
                        ctrl_d  = CTRL_STALL;
                        state_d = ST_MD_WAIT;
                    end
                end else if (load_use) begin
                    ctrl_d  = CTRL_STALL;
                    state_d = ST_LOAD_USE;
                end else if (!imem_ready) begin
                    ctrl_d  = CTRL_FBUBBL;
                    state_d = ST_FETCH_WAIT;
                end
            end
            ST_LOAD_USE: begin
                state_d = ST_RUN;
            end
            ST_MD_WAIT: begin
                ctrl_d = CTRL_STALL;
                if (md_done) begin
                    state_d = ST_RUN;
                end
            end
            ST_FETCH_WAIT: begin
                // A redirect must let the PC move even while fetch is still pending.
                if (EX_br_taken) begin
                    ctrl_d = CTRL_REDIR;
                end else if (!imem_ready) begin
                    ctrl_d = CTRL_FBUBBL;
                end
                if (imem_ready) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // Outputs are forced quiet for the whole time reset is held, not just at an edge.
    always_comb begin
        ctrl = ctrl_d;
        if (!rst_n) begin
            ctrl = CTRL_IDLE;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (ctrl.pc_stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_RUN;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign pc_stall  = ctrl.pc_stall;
    assign stall     = ctrl.stall;
    assign IF_flush  = ctrl.if_flush;
    assign ID_flush  = ctrl.id_flush;
    assign hz_state  = state_q;
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: directed cycles push their
// hand-computed expected outputs, a negedge monitor pops and compares.
module tb_pipeline_hazard_ctrl;

    logic        clk;
    logic        rst_n;
    logic [4:0]  ID_rs1, ID_rs2, EX_rd;
    logic        ID_use_rs1, ID_use_rs2;
    logic        EX_mem_read, EX_br_taken, EX_md_start, md_done, imem_ready;
    logic        pc_stall, stall, IF_flush, ID_flush;
    logic [1:0]  hz_state;
    logic [15:0] stall_cnt;

    typedef struct packed {
        logic [3:0]  flags;   // {pc_stall, stall, IF_flush, ID_flush}
        logic [1:0]  st;
        logic [15:0] cnt;
        logic [7:0]  tag;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    logic stim_done = 1'b0;

    pipeline_hazard_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ID_rs1      (ID_rs1),
        .ID_rs2      (ID_rs2),
        .ID_use_rs1  (ID_use_rs1),
        .ID_use_rs2  (ID_use_rs2),
        .EX_rd       (EX_rd),
        .EX_mem_read (EX_mem_read),
        .EX_br_taken (EX_br_taken),
        .EX_md_start (EX_md_start),
        .md_done     (md_done),
        .imem_ready  (imem_ready),
        .pc_stall    (pc_stall),
        .stall       (stall),
        .IF_flush    (IF_flush),
        .ID_flush    (ID_flush),
        .hz_state    (hz_state),
        .stall_cnt   (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic rst, input logic [4:0] rs1, input logic u1,
                         input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                         input logic mr, input logic br, input logic mds,
                         input logic mdd, input logic imr);
        rst_n       = rst;
        ID_rs1      = rs1;
        ID_use_rs1  = u1;
        ID_rs2      = rs2;
        ID_use_rs2  = u2;
        EX_rd       = rd;
        EX_mem_read = mr;
        EX_br_taken = br;
        EX_md_start = mds;
        md_done     = mdd;
        imem_ready  = imr;
    endtask

    // One clock: inputs applied 1ns after the rising edge, expectation queued
    // for the monitor to check at the following falling edge.
    task automatic cyc(input logic [7:0] tag, input logic rst,
                       input logic [4:0] rs1, input logic u1,
                       input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                       input logic mr, input logic br, input logic mds,
                       input logic mdd, input logic imr,
                       input logic [3:0] fl, input logic [1:0] st, input logic [15:0] cnt);
        exp_t e;
        @(posedge clk);
        #1;
        drive(rst, rs1, u1, rs2, u2, rd, mr, br, mds, mdd, imr);
        e.flags = fl;
        e.st    = st;
        e.cnt   = cnt;
        e.tag   = tag;
        exp_q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            n_checks++;
            if ({pc_stall, stall, IF_flush, ID_flush} === e.flags &&
                hz_state === e.st && stall_cnt === e.cnt) begin
                n_pass++;
            end else begin
                $display("FAIL vec%0d: got flags(ps,st,iff,idf)=%b state=%0d cnt=%h, want flags=%b state=%0d cnt=%h",
                         e.tag, {pc_stall, stall, IF_flush, ID_flush}, hz_state, stall_cnt,
                         e.flags, e.st, e.cnt);
            end
        end
    end

    initial begin
        drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        //        tag rst rs1 u1 rs2 u2 rd mr br mds mdd imr flags st cnt
        // reset holds outputs quiet even with branch + load-use present
        cyc(8'd0,  0, 5, 1, 0, 0, 5, 1, 1, 0, 0, 1, 4'b0000, 2'd0, 16'd0);
        cyc(8'd1,  1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 4'b0000, 2'd0, 16'd0);
        // lw x5 in EX, add x6,x5,x1 in ID
        cyc(8'd2,  1, 5, 1, 1, 1, 5, 1, 0, 0, 0, 1, 4'b1101, 2'd0, 16'd0);
        cyc(8'd3,  1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 4'b0000, 2'd1, 16'd1);
        cyc(8'd4,  1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 4'b0000, 2'd0, 16'd1);
        // x0 destination is never a hazard
        cyc(8'd5,  1, 0, 1, 0, 1, 0, 1, 0, 0, 0, 1, 4'b0000, 2'd0, 16'd1);
        // hazard through rs2, then branch ignored in LOAD_USE
        cyc(8'd6,  1, 3, 1, 7, 1, 7, 1, 0, 0, 0, 1, 4'b1101, 2'd0, 16'd1);
        cyc(8'd7,  1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 4'b0000, 2'd1, 16'd2);
        // matching rs1 but not read
        cyc(8'd8,  1, 9, 0, 0, 0, 9, 1, 0, 0, 0, 1, 4'b0000, 2'd0, 16'd2);
        // branch beats load-use
        cyc(8'd9,  1, 5, 1, 1, 1, 5, 1, 1, 0, 0, 1, 4'b0011, 2'd0, 16'd2);
        cyc(8'd10, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 4'b0000, 2'd0, 16'd2);
        // reset so the mul/div count starts from zero
        cyc(8'd11, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 4'b0000, 2'd0, 16'd0);
        cyc(8'd12, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 4'b0000, 2'd0, 16'd0);
        // md start, md_done 5 cycles later: 6 stalled cycles
        cyc(8'd13, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 4'b1101, 2'd0, 16'd0);
        cyc(8'd14, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 4'b1101, 2'd2, 16'd1);
        cyc(8'd15, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 4'b1101, 2'd2, 16'd2);
        cyc(8'd16, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 4'b1101, 2'd2, 16'd3);
        cyc(8'd17, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 4'b1101, 2'd2, 16'd4);
        cyc(8'd18, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 4'b1101, 2'd2, 16'd5);
        cyc(8'd19, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 4'b0000, 2'd0, 16'd6);
        // md_done together with start skips MD_WAIT
        cyc(8'd20, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 4'b0000, 2'd0, 16'd6);
        cyc(8'd21, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 4'b0000, 2'd0, 16'd6);
        // imem not ready 3 cycles, branch in the second
        cyc(8'd22, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b1010, 2'd0, 16'd6);
        cyc(8'd23, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 4'b0011, 2'd3, 16'd7);
        cyc(8'd24, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b1010, 2'd3, 16'd7);
        cyc(8'd25, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 4'b0000, 2'd3, 16'd8);
        cyc(8'd26, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 4'b0000, 2'd0, 16'd8);
        // long MD_WAIT to drive the counter into saturation
        cyc(8'd27, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 4'b1101, 2'd0, 16'd8);
        for (int i = 0; i < 65530; i++) begin
            @(posedge clk);
            #1;
            drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        end
        cyc(8'd28, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 4'b1101, 2'd2, 16'hFFFF);
        cyc(8'd29, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 4'b1101, 2'd2, 16'hFFFF);
        // async reset mid MD_WAIT, checked before the next rising edge
        cyc(8'd30, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 4'b0000, 2'd0, 16'd0);
        cyc(8'd31, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 4'b0000, 2'd0, 16'd0);
        // first post-reset cycle behaves as RUN: a load-use is acted on
        cyc(8'd32, 1, 4, 1, 0, 0, 4, 1, 0, 0, 0, 1, 4'b1101, 2'd0, 16'd0);
        cyc(8'd33, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 4'b0000, 2'd1, 16'd1);
        cyc(8'd34, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 4'b0000, 2'd0, 16'd1);
        stim_done = 1'b1;
    end

    initial begin
        int guard;
        guard = 0;
        while (!(stim_done && exp_q.size() == 0) && guard < 90000) begin
            @(posedge clk);
            guard++;
        end
        if (guard >= 90000) begin
            n_checks++;
            $display("FAIL timeout: got %0d expectations left, want 0", exp_q.size());
        end
        @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
